debug_cmd: RTL and testbench
============================

Name: debug_cmd

Overview:
- Upstream command stage for the Z80 single-step debug path.
- Consumes bytes from the UART receiver and parses a small binary command protocol.
- Drives run/halt, step-count, breakpoint and Z80-reset controls into the clock-stepping/trace stage.
- Returns a one-byte ACK/NAK per command through a valid/ready handshake to the UART transmit arbiter.

Parameters:
- TIMEOUT_CYCLES, 5000000: max clk cycles allowed between bytes of one command before abort.
- RST_CYCLES, 16: length of the z80_rst_req pulse in clk cycles (must be >= 1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- rx_data  in  8  received byte; valid only when rx_valid is high.
- rx_valid  in  1  one-cycle pulse, new byte available; cannot be back-pressured.
- tx_data  out  8  reply byte.
- tx_valid  out  1  reply pending.
- tx_ready  in  1  consumer accepts tx_data when tx_valid && tx_ready.
- step_busy  in  1  stepper is executing a step burst.
- bp_hit  in  1  one-cycle pulse, stepper reached bp_addr.
- run  out  1  free-run enable to stepper.
- step_start  out  1  one-cycle pulse, begin step burst.
- step_count  out  16  number of Z80 clocks for the burst; stable from step_start until the next S command.
- bp_addr  out  16  breakpoint address.
- bp_en  out  1  breakpoint enable.
- z80_rst_req  out  1  Z80 reset request.
- overrun  out  1  sticky: a byte arrived while a reply was pending.

Behaviour:
- Reset (clk edge with rst=1) sets all outputs to 0 and state to IDLE.
  - Covers tx_data, tx_valid, run, step_start, step_count, bp_addr, bp_en, z80_rst_req and overrun.
  - Clears the timeout counter and the reset-pulse counter.
  - Reset mid-command discards any partial command and sends no reply.
- Opcodes (first byte):
  - 0x52 'R': run=1.
  - 0x48 'H': run=0.
  - 0x53 'S' + hi + lo: load step_count, pulse step_start.
  - 0x42 'B' + hi + lo: bp_addr={hi,lo}, bp_en=1.
  - 0x43 'C': bp_en=0.
  - 0x58 'X': run=0 and z80_rst_req high for exactly RST_CYCLES cycles.
- Replies: 0x06 ACK on accepted command; 0x15 NAK otherwise.
- States: IDLE, ARG_HI, ARG_LO, EXEC, REPLY.
  - IDLE: on rx_valid, latch the opcode.
    - Known 0-arg opcode -> EXEC.
    - 'S' or 'B' -> ARG_HI.
    - Unknown opcode -> REPLY with NAK.
  - ARG_HI: on rx_valid, latch the high byte -> ARG_LO.
  - ARG_LO: on rx_valid, latch the low byte -> EXEC.
  - Timeout in ARG_HI/ARG_LO: the counter resets on every accepted byte. When it reaches TIMEOUT_CYCLES-1 with no byte, go to REPLY with NAK and discard partial arguments.
  - EXEC (exactly one cycle): apply the command and go to REPLY with ACK, except:
    - 'S' with count 0 -> NAK, no pulse.
    - 'S' while step_busy=1 -> NAK, no pulse, step_count unchanged.
  - REPLY: tx_valid=1 with tx_data held. On tx_valid && tx_ready, drop tx_valid and go to IDLE the same edge.
  - rx_valid in REPLY or EXEC: byte dropped, overrun set to 1; it is cleared only by rst.
- Latency:
  - Command effect appears the cycle after EXEC. Example: the final byte's rx_valid at cycle n gives step_start=1 at cycle n+2 and tx_valid=1 from n+2.
  - Byte accepted on the same cycle rx_valid is seen in IDLE/ARG states.
- bp_hit: forces run=0 the next cycle.
  - Has priority over an 'R' executed the same cycle.
  - Independent of parser state; does not generate a reply.
- z80_rst_req:
  - The counter runs independently of the parser, so further commands are accepted during the pulse.
  - A second 'X' during the pulse restarts the count to a full RST_CYCLES.
- step_start is a one-cycle pulse only; step_count holds its value afterwards.

Decomposition:
- Shared package debug_pkg holds:
  - opcode constants (OP_RUN, OP_HALT, OP_STEP, OP_BP_SET, OP_BP_CLR, OP_RESET);
  - reply constants (RSP_ACK=0x06, RSP_NAK=0x15);
  - the state encoding.
- One natural sub-module, debug_timeout: a loadable down-counter with restart and expired outputs.
- The reset-pulse counter stays inline.

Test Plan:
- Step command: rx bytes 0x53,0x00,0x05 with step_busy=0 -> step_count=0x0005, single step_start pulse 2 cycles after the last byte, reply 0x06.
- Breakpoint set and hit: rx 0x42,0x12,0x34 then 0x52 -> bp_addr=0x1234, bp_en=1, run=1, two ACKs. Then pulse bp_hit -> run=0 next cycle, no reply byte.
- Invalid commands: rx 0x7A -> NAK, no output change. rx 0x53,0x00,0x00 -> NAK, no step_start. rx 0x53,0x00,0x09 with step_busy=1 -> NAK, step_count unchanged.
- Timeout: rx 0x42,0x12 then silence for TIMEOUT_CYCLES (set to 100) -> NAK; bp_addr and bp_en unchanged; the next 0x43 is parsed as a fresh opcode -> ACK.
- Backpressure and overrun: hold tx_ready=0 after an 'R', send 0x48 -> tx_data stays 0x06, overrun=1, run stays 1. Raise tx_ready -> tx_valid drops, state returns to IDLE.
- Reset interaction:
  - 'X' with RST_CYCLES=16 -> z80_rst_req high exactly 16 cycles.
  - A second 'X' at cycle 10 -> high 26 cycles total.
  - Assert rst mid-'S' (after the opcode byte) -> all outputs 0; then 0x52 -> run=1, ACK.

Source files
------------

// File: rtl/debug_cmd_pkg.sv
// Shared definitions for the Z80 debug command path.
// Holds the command opcode bytes, the reply bytes and the parser state
// encoding, plus two small opcode classification helpers.
package debug_pkg;

  localparam logic [7:0] OP_RUN    = 8'h52;  // 'R'
  localparam logic [7:0] OP_HALT   = 8'h48;  // 'H'
  localparam logic [7:0] OP_STEP   = 8'h53;  // 'S' + hi + lo
  localparam logic [7:0] OP_BP_SET = 8'h42;  // 'B' + hi + lo
  localparam logic [7:0] OP_BP_CLR = 8'h43;  // 'C'
  localparam logic [7:0] OP_RESET  = 8'h58;  // 'X'

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG_HI,
    ST_ARG_LO,
    ST_EXEC,
    ST_REPLY
  } state_t;

  function automatic logic op_is_0arg(input logic [7:0] op);
    return (op == OP_RUN) || (op == OP_HALT) || (op == OP_BP_CLR) || (op == OP_RESET);
  endfunction

  function automatic logic op_has_args(input logic [7:0] op);
    return (op == OP_STEP) || (op == OP_BP_SET);
  endfunction

endpackage

// File: rtl/debug_cmd_if.sv
// Byte-stream link between the UART and the debug command parser.
//   rx_data/rx_valid : received byte, one-cycle valid pulse, no back-pressure
//   tx_data/tx_valid/tx_ready : reply byte with valid/ready handshake
// master: UART side (drives rx, consumes tx); slave: debug_cmd.
interface debug_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/debug_timeout.sv
// Inter-byte timeout for the command parser.
// Loadable down-counter: restart reloads TIMEOUT_CYCLES-1, otherwise it
// counts down and sticks at zero. expired is high while the count is zero,
// i.e. TIMEOUT_CYCLES-1 cycles after the last restart.
//   clk, rst  : clock, synchronous active-high reset (clears the count)
//   restart   : reload the counter
//   expired   : count has reached zero
module debug_timeout #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/debug_cmd.sv
// Command stage of the Z80 single-step debug path.
// Parses R/H/S/B/C/X commands arriving byte by byte from the UART, drives the
// stepper controls and returns one ACK/NAK byte per command.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : UART rx byte stream in, reply byte handshake out
//   step_busy    : stepper is running a burst (S is refused while high)
//   bp_hit       : stepper reached bp_addr, forces run low next cycle
//   run          : free-run enable
//   step_start   : one-cycle pulse starting a burst of step_count clocks
//   step_count   : burst length, held until the next accepted S
//   bp_addr/bp_en: breakpoint address and enable
//   z80_rst_req  : Z80 reset request, RST_CYCLES cycles long
//   overrun      : sticky, a byte arrived while the parser could not take it
module debug_cmd
  import debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int RST_CYCLES     = 16
) (
  input  logic              clk,
  input  logic              rst,
  debug_cmd_if.slave        bus,
  input  logic              step_busy,
  input  logic              bp_hit,
  output logic              run,
  output logic              step_start,
  output logic [15:0]       step_count,
  output logic [15:0]       bp_addr,
  output logic              bp_en,
  output logic              z80_rst_req,
  output logic              overrun
);
  localparam int RW = $clog2(RST_CYCLES + 1);

  state_t      state_q, state_nx;
  logic [7:0]  op_q, op_nx;
  logic [7:0]  hi_q, hi_nx;
  logic [7:0]  lo_q, lo_nx;
  logic [7:0]  tx_data_q, tx_data_nx;
  logic        tx_valid_q, tx_valid_nx;
  logic        run_q, run_nx;
  logic        step_start_q, step_start_nx;
  logic [15:0] step_count_q, step_count_nx;
  logic [15:0] bp_addr_q, bp_addr_nx;
  logic        bp_en_q, bp_en_nx;
  logic        overrun_q, overrun_nx;
  logic [RW-1:0] rst_cnt_q;
  logic        rst_load;

  logic        in_arg;
  logic        to_restart;
  logic        to_expired;

  // The timeout only matters while waiting for argument bytes; holding it
  // in restart elsewhere means every argument phase starts with a full window.
  assign in_arg     = (state_q == ST_ARG_HI) || (state_q == ST_ARG_LO);
  assign to_restart = !in_arg || bus.rx_valid;

  debug_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .restart (to_restart),
    .expired (to_expired)
  );

  always_comb begin
    state_nx      = state_q;
    op_nx         = op_q;
    hi_nx         = hi_q;
    lo_nx         = lo_q;
    tx_data_nx    = tx_data_q;
    tx_valid_nx   = tx_valid_q;
    run_nx        = run_q;
    step_start_nx = 1'b0;
    step_count_nx = step_count_q;
    bp_addr_nx    = bp_addr_q;
    bp_en_nx      = bp_en_q;
    overrun_nx    = overrun_q;
    rst_load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          op_nx = bus.rx_data;
          if (op_is_0arg(bus.rx_data)) begin
            state_nx = ST_EXEC;
          end else if (op_has_args(bus.rx_data)) begin
            state_nx = ST_ARG_HI;
          end else begin
            tx_data_nx  = RSP_NAK;
            tx_valid_nx = 1'b1;
            state_nx    = ST_REPLY;
          end
        end
      end

      ST_ARG_HI: begin
        if (bus.rx_valid) begin
          hi_nx    = bus.rx_data;
          state_nx = ST_ARG_LO;
        end else if (to_expired) begin
          hi_nx       = 8'h00;
          tx_data_nx  = RSP_NAK;
          tx_valid_nx = 1'b1;
          state_nx    = ST_REPLY;
        end
      end

      ST_ARG_LO: begin
        if (bus.rx_valid) begin
          lo_nx    = bus.rx_data;
          state_nx = ST_EXEC;
        end else if (to_expired) begin
          hi_nx       = 8'h00;
          lo_nx       = 8'h00;
          tx_data_nx  = RSP_NAK;
          tx_valid_nx = 1'b1;
          state_nx    = ST_REPLY;
        end
      end

      ST_EXEC: begin
        tx_data_nx  = RSP_ACK;
        tx_valid_nx = 1'b1;
        state_nx    = ST_REPLY;
        if (bus.rx_valid) overrun_nx = 1'b1;
        case (op_q)
          OP_RUN:    run_nx = 1'b1;
          OP_HALT:   run_nx = 1'b0;
          OP_STEP: begin
            // A zero-length burst or a busy stepper leaves step_count alone.
            if (({hi_q, lo_q} == 16'h0000) || step_busy) begin
              tx_data_nx = RSP_NAK;
            end else begin
              step_count_nx = {hi_q, lo_q};
              step_start_nx = 1'b1;
            end
          end
          OP_BP_SET: begin
            bp_addr_nx = {hi_q, lo_q};
            bp_en_nx   = 1'b1;
          end
          OP_BP_CLR: bp_en_nx = 1'b0;
          OP_RESET: begin
            run_nx   = 1'b0;
            rst_load = 1'b1;
          end
          default:   tx_data_nx = RSP_NAK;
        endcase
      end

      ST_REPLY: begin
        if (bus.rx_valid) overrun_nx = 1'b1;
        if (bus.tx_ready) begin
          tx_valid_nx = 1'b0;
          state_nx    = ST_IDLE;
        end
      end

      default: state_nx = ST_IDLE;
    endcase

    // Breakpoint wins over an R executing in the same cycle.
    if (bp_hit) run_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= 8'h00;
      hi_q         <= 8'h00;
      lo_q         <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      run_q        <= 1'b0;
      step_start_q <= 1'b0;
      step_count_q <= 16'h0000;
      bp_addr_q    <= 16'h0000;
      bp_en_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_nx;
      op_q         <= op_nx;
      hi_q         <= hi_nx;
      lo_q         <= lo_nx;
      tx_data_q    <= tx_data_nx;
      tx_valid_q   <= tx_valid_nx;
      run_q        <= run_nx;
      step_start_q <= step_start_nx;
      step_count_q <= step_count_nx;
      bp_addr_q    <= bp_addr_nx;
      bp_en_q      <= bp_en_nx;
      overrun_q    <= overrun_nx;
    end
  end

  // Z80 reset pulse: runs on its own so commands keep flowing; a new X
  // reloads a full RST_CYCLES count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt_q <= '0;
    end else if (rst_load) begin
      rst_cnt_q <= RW'(RST_CYCLES);
    end else if (rst_cnt_q != '0) begin
      rst_cnt_q <= rst_cnt_q - RW'(1);
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign run          = run_q;
  assign step_start   = step_start_q;
  assign step_count   = step_count_q;
  assign bp_addr      = bp_addr_q;
  assign bp_en        = bp_en_q;
  assign z80_rst_req  = (rst_cnt_q != '0);
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_debug_cmd.sv
// Testbench for debug_cmd: directed protocol scenarios followed by random
// command traffic, all compared against a command-level reference model.
module tb_debug_cmd;
  localparam int TO_CYC  = 100;
  localparam int RST_CYC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_busy;
  logic        bp_hit;
  logic        run;
  logic        step_start;
  logic [15:0] step_count;
  logic [15:0] bp_addr;
  logic        bp_en;
  logic        z80_rst_req;
  logic        overrun;

  debug_cmd_if bus();

  debug_cmd #(.TIMEOUT_CYCLES(TO_CYC), .RST_CYCLES(RST_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .step_busy   (step_busy),
    .bp_hit      (bp_hit),
    .run         (run),
    .step_start  (step_start),
    .step_count  (step_count),
    .bp_addr     (bp_addr),
    .bp_en       (bp_en),
    .z80_rst_req (z80_rst_req),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic        m_run;
  logic [15:0] m_step_count;
  logic [15:0] m_bp_addr;
  logic        m_bp_en;
  logic        m_overrun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_run = 0; m_step_count = 0; m_bp_addr = 0; m_bp_en = 0; m_overrun = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx_data"}, bus.tx_data, 0);
    check({tag, "_tx_valid"}, bus.tx_valid, 0);
    check({tag, "_run"}, run, 0);
    check({tag, "_step_start"}, step_start, 0);
    check({tag, "_step_count"}, step_count, 0);
    check({tag, "_bp_addr"}, bp_addr, 0);
    check({tag, "_bp_en"}, bp_en, 0);
    check({tag, "_z80_rst_req"}, z80_rst_req, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_run"}, run, m_run);
    check({tag, "_step_count"}, step_count, m_step_count);
    check({tag, "_bp_addr"}, bp_addr, m_bp_addr);
    check({tag, "_bp_en"}, bp_en, m_bp_en);
    check({tag, "_overrun"}, overrun, m_overrun);
  endtask

  function automatic logic takes_args(input logic [7:0] op);
    return (op == 8'h53) || (op == 8'h42);
  endfunction

  // Command-level model: what a whole command does, and what reply it earns.
  task automatic model_apply(input logic [7:0] b0, b1, b2,
                             output logic [7:0] rsp, output logic pulse, output int lat);
    rsp = 8'h06; pulse = 0; lat = 1;
    case (b0)
      8'h52: m_run = 1;
      8'h48: m_run = 0;
      8'h43: m_bp_en = 0;
      8'h58: m_run = 0;
      8'h53: begin
        if ({b1, b2} == 16'h0000 || step_busy) rsp = 8'h15;
        else begin m_step_count = {b1, b2}; pulse = 1; end
      end
      8'h42: begin m_bp_addr = {b1, b2}; m_bp_en = 1; end
      default: begin rsp = 8'h15; lat = 0; end
    endcase
  endtask

  // Send one full command with optional gaps between bytes, check the reply,
  // its latency after the last byte, the step pulse, and resulting outputs.
  task automatic run_cmd(input string tag, input logic [7:0] b0, b1, b2, input int max_gap);
    logic [7:0] rsp;
    logic pulse;
    int lat;
    int k;
    model_apply(b0, b1, b2, rsp, pulse, lat);
    send_byte(b0);
    if (takes_args(b0)) begin
      repeat ($urandom_range(0, max_gap)) tick();
      send_byte(b1);
      repeat ($urandom_range(0, max_gap)) tick();
      send_byte(b2);
    end
    k = 0;
    while (!bus.tx_valid && k < 8) begin
      tick();
      k++;
    end
    check({tag, "_reply_valid"}, bus.tx_valid, 1);
    check({tag, "_reply_data"}, bus.tx_data, rsp);
    check({tag, "_latency"}, k, lat);
    check({tag, "_step_start"}, step_start, pulse);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check({tag, "_tx_drop"}, bus.tx_valid, 0);
    check({tag, "_step_start_end"}, step_start, 0);
    check_state(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hi_cnt;
    logic [7:0] b0, b1, b2;

    rst = 1; step_busy = 0; bp_hit = 0;
    bus.rx_data = 0; bus.rx_valid = 0; bus.tx_ready = 0;
    model_reset();
    tick(); tick();
    rst = 0;
    check_zero("reset");

    // step command
    run_cmd("step5", 8'h53, 8'h00, 8'h05, 0);

    // breakpoint set, run, then breakpoint hit
    run_cmd("bpset", 8'h42, 8'h12, 8'h34, 2);
    run_cmd("run", 8'h52, 0, 0, 0);
    bp_hit = 1;
    tick();
    bp_hit = 0;
    m_run = 0;
    check("bphit_run", run, 0);
    check("bphit_no_reply", bus.tx_valid, 0);
    tick();
    check("bphit_no_reply2", bus.tx_valid, 0);
    check_state("bphit");

    // invalid commands
    run_cmd("unknown", 8'h7A, 0, 0, 0);
    run_cmd("step0", 8'h53, 8'h00, 8'h00, 0);
    step_busy = 1;
    run_cmd("stepbusy", 8'h53, 8'h00, 8'h09, 0);
    step_busy = 0;

    // timeout between argument bytes
    send_byte(8'h42);
    send_byte(8'h12);
    k = 0;
    while (!bus.tx_valid && k < 3 * TO_CYC) begin
      tick();
      k++;
    end
    check("timeout_cycles", k, TO_CYC);
    check("timeout_reply", bus.tx_data, 8'h15);
    bus.tx_ready = 1; tick(); bus.tx_ready = 0;
    check_state("timeout");
    run_cmd("after_timeout_clr", 8'h43, 0, 0, 0);

    // backpressure and overrun
    run_cmd("run2", 8'h52, 0, 0, 0);
    send_byte(8'h52);
    m_run = 1;
    tick();
    check("bp_pending", bus.tx_valid, 1);
    send_byte(8'h48);
    m_overrun = 1;
    check("bp_hold_data", bus.tx_data, 8'h06);
    check("bp_hold_valid", bus.tx_valid, 1);
    check("bp_overrun", overrun, 1);
    check("bp_run_kept", run, 1);
    bus.tx_ready = 1; tick(); bus.tx_ready = 0;
    check("bp_release", bus.tx_valid, 0);
    run_cmd("halt_after_overrun", 8'h48, 0, 0, 0);

    // Z80 reset pulse length
    bus.tx_ready = 1;
    hi_cnt = 0;
    send_byte(8'h58);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (z80_rst_req) hi_cnt++;
    end
    check("xpulse_len", hi_cnt, RST_CYC);
    // second X ten cycles after the first pulse begins
    hi_cnt = 0;
    send_byte(8'h58);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (z80_rst_req) hi_cnt++;
    end
    send_byte(8'h58);
    if (z80_rst_req) hi_cnt++;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (z80_rst_req) hi_cnt++;
    end
    check("xpulse_retrigger_len", hi_cnt, 26);
    bus.tx_ready = 0;
    m_run = 0;
    check("x_tx_idle", bus.tx_valid, 0);
    check_state("x");

    // random command traffic
    for (int i = 0; i < 40; i++) begin
      step_busy = ($urandom_range(0, 3) == 0);
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0: b0 = 8'h52;
        1: b0 = 8'h48;
        2: b0 = 8'h53;
        3: b0 = 8'h42;
        4: b0 = 8'h43;
        5: b0 = 8'h58;
        6: begin b0 = 8'h53; if ($urandom_range(0, 1) == 0) begin b1 = 0; b2 = 0; end end
        default: begin
          b0 = 8'($urandom_range(0, 255));
          if (b0 == 8'h52 || b0 == 8'h48 || b0 == 8'h53 || b0 == 8'h42 ||
              b0 == 8'h43 || b0 == 8'h58) b0 = b0 ^ 8'h80;
        end
      endcase
      run_cmd("random", b0, b1, b2, 3);
    end
    step_busy = 0;

    // reset in the middle of an S command
    send_byte(8'h53);
    rst = 1;
    tick();
    rst = 0;
    model_reset();
    check_zero("midreset");
    tick(); tick(); tick();
    check("midreset_no_reply", bus.tx_valid, 0);
    run_cmd("run_after_reset", 8'h52, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
